// File: rtl/l1_buffer_addr_ctrl.sv
// Global write/read pointer manager for the per-pixel L1 circular buffers.
// Optional dropped-L1A counter enabled by defining L1_OVERFLOW_CNT_EN.
//
// state  | meaning
// IDLE   | no read strobe; waiting for a committed slot while ready
// ISSUE  | one rdEn per cycle while ready, draining committed slots
module l1_buffer_addr_ctrl #(
  parameter int ADDRWIDTH = 7,
  parameter int WR_LAT    = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 L1A,
  input  logic                 ready,
  output logic                 L1AOut,
  output logic [ADDRWIDTH-1:0] wrAddr,
  output logic                 rdEn,
  output logic [ADDRWIDTH-1:0] rdAddr,
  output logic                 dataValid,
  output logic [ADDRWIDTH:0]   occupancy,
  output logic                 full,
  output logic                 empty,
  output logic [15:0]          overflowCnt
);

  localparam int AW = ADDRWIDTH;
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t state_q, state_d;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]       alloc_ptr_q, alloc_ptr_d;
  logic [AW:0]       commit_ptr_q, commit_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [WR_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [AW-1:0]     pipe_a_q [WR_LAT];
  logic [AW-1:0]     pipe_a_d [WR_LAT];
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic              l1a_out_q, l1a_out_d;
  logic [RD_LAT-1:0] dv_q, dv_d;
  logic              accept;
  logic              rd_en;

  assign occupancy = alloc_ptr_q - rd_ptr_q;
  assign full      = (occupancy == DEPTH_V);
  assign empty     = (commit_ptr_q == rd_ptr_q);
  assign accept    = L1A && !full;
  assign L1AOut    = l1a_out_q;
  assign rdEn      = rd_en;
  assign rdAddr    = rd_ptr_q[AW-1:0];
  assign dataValid = dv_q[RD_LAT-1];

  // wrAddr follows the stage aligned with the SRAM write and holds between writes.
  assign wrAddr    = pipe_v_q[WR_LAT-1] ? pipe_a_q[WR_LAT-1] : wr_addr_q;

  always_comb begin
    alloc_ptr_d  = alloc_ptr_q + {{AW{1'b0}}, accept};
    l1a_out_d    = accept;
    wr_addr_d    = wrAddr;
    pipe_v_d     = '0;
    for (int i = 0; i < WR_LAT; i++) begin
      pipe_a_d[i] = '0;
    end
    pipe_v_d[0]  = accept;
    pipe_a_d[0]  = alloc_ptr_q[AW-1:0];
    for (int i = 1; i < WR_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_a_d[i] = pipe_a_q[i-1];
    end
    commit_ptr_d = commit_ptr_q + {{AW{1'b0}}, pipe_v_q[WR_LAT-1]};
  end

  // Decisions look at next-cycle pointers so a slot committing this cycle
  // can be read right after its write, and a burst never reads an empty slot.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (ready && (commit_ptr_d != rd_ptr_q)) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ready) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (ready && (commit_ptr_d != rd_ptr_d)) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dv_d    = '0;
    dv_d[0] = rd_en;
    for (int i = 1; i < RD_LAT; i++) begin
      dv_d[i] = dv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      alloc_ptr_q  <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pipe_v_q     <= '0;
      wr_addr_q    <= '0;
      l1a_out_q    <= 1'b0;
      dv_q         <= '0;
      for (int i = 0; i < WR_LAT; i++) begin
        pipe_a_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      alloc_ptr_q  <= alloc_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pipe_v_q     <= pipe_v_d;
      wr_addr_q    <= wr_addr_d;
      l1a_out_q    <= l1a_out_d;
      dv_q         <= dv_d;
      for (int i = 0; i < WR_LAT; i++) begin
        pipe_a_q[i] <= pipe_a_d[i];
      end
    end
  end

`ifdef L1_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (L1A && full && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign overflowCnt = ovf_cnt_q;
`else
  assign overflowCnt = 16'h0;
`endif

endmodule

// File: tb/tb_l1_buffer_addr_ctrl.sv
// Directed bench for l1_buffer_addr_ctrl: table for the single-event timing,
// hand sequences for fill, drain, wrap, simultaneous alloc/read and mid-burst reset.
module tb_l1_buffer_addr_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        L1A = 1'b0;
  logic        ready = 1'b0;
  logic        L1AOut;
  logic [6:0]  wrAddr;
  logic        rdEn;
  logic [6:0]  rdAddr;
  logic        dataValid;
  logic [7:0]  occupancy;
  logic        full;
  logic        empty;
  logic [15:0] overflowCnt;
  logic [26:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef L1_OVERFLOW_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  l1_buffer_addr_ctrl #(.ADDRWIDTH(7), .WR_LAT(3), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .L1A(L1A), .ready(ready),
    .L1AOut(L1AOut), .wrAddr(wrAddr), .rdEn(rdEn), .rdAddr(rdAddr),
    .dataValid(dataValid), .occupancy(occupancy), .full(full),
    .empty(empty), .overflowCnt(overflowCnt)
  );

  always #5 clk = ~clk;

  assign obs = {L1AOut, rdEn, dataValid, wrAddr, rdAddr, occupancy, full, empty};

  typedef struct packed {
    logic        l1a;
    logic        rdy;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mkv(input logic l1a, input logic rdy, input logic lo,
                               input logic re, input logic dv, input logic [6:0] wa,
                               input logic [6:0] ra, input logic [7:0] occ,
                               input logic fu, input logic em);
    return {l1a, rdy, lo, re, dv, wa, ra, occ, fu, em};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    L1A   = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < 10; c++) vecs[c] = mkv(0, 1, 0, 0, 0, 7'd0, 7'd0, 8'd0, 0, 1);
    vecs[10] = mkv(1, 1, 0, 0, 0, 7'd0, 7'd0, 8'd0, 0, 1);
    vecs[11] = mkv(0, 1, 1, 0, 0, 7'd0, 7'd0, 8'd1, 0, 1);
    vecs[12] = mkv(0, 1, 0, 0, 0, 7'd0, 7'd0, 8'd1, 0, 1);
    vecs[13] = mkv(0, 1, 0, 0, 0, 7'd0, 7'd0, 8'd1, 0, 1);
    vecs[14] = mkv(0, 1, 0, 1, 0, 7'd0, 7'd0, 8'd1, 0, 0);
    vecs[15] = mkv(0, 1, 0, 0, 1, 7'd0, 7'd1, 8'd0, 0, 1);
    vecs[16] = mkv(0, 1, 0, 0, 0, 7'd0, 7'd1, 8'd0, 0, 1);

    // Single event: reset state, then L1A at cycle 10
    do_reset();
    #1;
    check("reset_ovf", overflowCnt, 0);
    for (int i = 0; i < 17; i++) begin
      L1A   = vecs[i].l1a;
      ready = vecs[i].rdy;
      #1;
      check($sformatf("single_c%0d", i), obs, vecs[i].exp);
      tick();
    end

    // Fill 128 slots with ready low, then two dropped L1As
    do_reset();
    for (int j = 0; j < 134; j++) begin
      L1A   = (j < 130);
      ready = 1'b0;
      #1;
      check($sformatf("fill_l1aout_c%0d", j), L1AOut, (j >= 1 && j <= 128));
      check($sformatf("fill_wraddr_c%0d", j), wrAddr, (j < 3) ? 0 : ((j - 3 > 127) ? 127 : j - 3));
      check($sformatf("fill_full_c%0d", j), full, (j >= 128));
      tick();
    end
    #1;
    check("fill_occ", occupancy, 128);
    check("fill_empty", empty, 0);
    check("fill_ovf", overflowCnt, OVF_EN ? 2 : 0);

    // Drain from full; an L1A in the first read cycle is still dropped
    for (int j = 0; j < 131; j++) begin
      L1A   = (j == 1);
      ready = 1'b1;
      #1;
      check($sformatf("drain_rden_c%0d", j), rdEn, (j >= 1 && j <= 128));
      if (j >= 1 && j <= 128) check($sformatf("drain_rdaddr_c%0d", j), rdAddr, j - 1);
      check($sformatf("drain_dv_c%0d", j), dataValid, (j >= 2 && j <= 129));
      if (j == 2) check("drain_drop_l1aout", L1AOut, 0);
      if (j == 129) begin
        check("drain_occ_end", occupancy, 0);
        check("drain_empty_end", empty, 1);
      end
      tick();
    end
    #1;
    check("drain_ovf", overflowCnt, OVF_EN ? 3 : 0);
    check("drain_full", full, 0);

    // Wrap: 200 back-to-back L1As with ready high
    for (int j = 0; j < 207; j++) begin
      L1A   = (j < 200);
      ready = 1'b1;
      #1;
      check($sformatf("wrap_rden_c%0d", j), rdEn, (j >= 4 && j <= 203));
      if (j >= 4 && j <= 203) check($sformatf("wrap_rdaddr_c%0d", j), rdAddr, (j - 4) % 128);
      check($sformatf("wrap_l1aout_c%0d", j), L1AOut, (j >= 1 && j <= 200));
      check($sformatf("wrap_full_c%0d", j), full, 0);
      tick();
    end
    #1;
    check("wrap_occ_end", occupancy, 0);
    check("wrap_empty_end", empty, 1);
    check("wrap_ovf", overflowCnt, OVF_EN ? 3 : 0);

    // Simultaneous accept and read at occupancy 5
    for (int j = 0; j < 11; j++) begin
      L1A   = (j < 5);
      ready = 1'b0;
      tick();
    end
    #1;
    check("sim_occ_pre", occupancy, 5);
    check("sim_empty_pre", empty, 0);
    check("sim_wraddr_pre", wrAddr, 76);
    L1A = 1'b0; ready = 1'b1; #1;
    check("sim_idle_rden", rdEn, 0);
    tick();
    L1A = 1'b1; ready = 1'b1; #1;
    check("sim_rden", rdEn, 1);
    check("sim_rdaddr", rdAddr, 72);
    check("sim_occ_same", occupancy, 5);
    tick();
    L1A = 1'b0; ready = 1'b0; #1;
    check("sim_rden_off", rdEn, 0);
    check("sim_l1aout", L1AOut, 1);
    check("sim_occ_after", occupancy, 5);
    check("sim_rdaddr_next", rdAddr, 73);
    tick();
    #1;
    check("sim_wraddr_hold", wrAddr, 76);
    tick();
    #1;
    check("sim_wraddr_next", wrAddr, 77);
    tick();

    // Reset during a read burst with writes in flight
    L1A = 1'b1; ready = 1'b1;
    tick();
    #1;
    check("rst_burst_rden", rdEn, 1);
    check("rst_burst_rdaddr", rdAddr, 73);
    tick();
    tick();
    L1A = 1'b0; reset = 1'b0; #1;
    check("rst_pre_rden", rdEn, 1);
    tick();
    reset = 1'b1; ready = 1'b0; #1;
    check("rst_rden", rdEn, 0);
    check("rst_dv", dataValid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_l1aout", L1AOut, 0);
    check("rst_wraddr", wrAddr, 0);
    check("rst_rdaddr", rdAddr, 0);
    check("rst_ovf", overflowCnt, 0);
    tick();
    L1A = 1'b1;
    tick();
    L1A = 1'b0; #1;
    check("post_l1aout", L1AOut, 1);
    check("post_occ", occupancy, 1);
    tick();
    #1;
    check("post_empty_stale", empty, 1);
    check("post_wraddr_a", wrAddr, 0);
    tick();
    #1;
    check("post_wraddr_b", wrAddr, 0);
    tick();
    #1;
    check("post_commit", empty, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
